// File: rtl/split_n_pkg.sv
// Shared types, limits and helpers for the N-way split.
package split_pkg;

  localparam int unsigned MAX_NOUT  = 16;
  localparam int unsigned MAX_DEPTH = 8;
  localparam int unsigned CNT_W     = 4;

  // Occupancy count, wide enough for 0..MAX_DEPTH.
  typedef logic [CNT_W-1:0] cnt_t;

  // Select width: at least one bit even for a single-output split.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/split_n_if.sv
// Join/split handshake bundle: L data channel, S select channel, NOUT outputs.
interface split_n_if
  import split_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NOUT  = 4
) ();

  localparam int unsigned SELW = sel_w(NOUT);

  logic                  l_valid;
  logic [WIDTH-1:0]      l_data;
  logic                  l_ready;
  logic                  s_valid;
  logic [SELW-1:0]       s_sel;
  logic                  s_bcast;
  logic                  s_ready;
  logic [NOUT-1:0]       r_valid;
  logic [NOUT*WIDTH-1:0] r_data;
  logic [NOUT-1:0]       r_ready;

  // Producer/consumer side.
  modport master (
    output l_valid, l_data, s_valid, s_sel, s_bcast, r_ready,
    input  l_ready, s_ready, r_valid, r_data
  );

  // Split block side.
  modport slave (
    input  l_valid, l_data, s_valid, s_sel, s_bcast, r_ready,
    output l_ready, s_ready, r_valid, r_data
  );

endinterface

// File: rtl/split_n_fifo.sv
// Per-output token FIFO; pointers wrap by compare-and-clear so DEPTH may be any value.
module split_fifo
  import split_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output cnt_t             count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  cnt_t             count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Push only into free space (no pass-through when full); pop only when non-empty.
  always_comb begin
    do_push = push_i && (count_q != CNT_W'(DEPTH));
    do_pop  = pop_i && (count_q != '0);
    wptr_d  = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = do_pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Token storage, cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/split_n.sv
// N-way split: joins an L data token with an S select token and routes it
// to one output FIFO, or to all of them in broadcast mode.
module split_n
  import split_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NOUT  = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  split_n_if.slave bus,
  output logic     sel_err
);

  localparam int unsigned SELW = sel_w(NOUT);

  if (NOUT < 2 || NOUT > MAX_NOUT) begin : g_bad_nout
    $error("split_n: NOUT out of range");
  end
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("split_n: DEPTH out of range");
  end

  cnt_t             cnt  [NOUT];
  logic [WIDTH-1:0] head [NOUT];
  logic [NOUT-1:0]  full;
  logic [NOUT-1:0]  hit;
  logic [NOUT-1:0]  push;
  logic [NOUT-1:0]  pop;
  logic             in_range;
  logic             tgt_space;
  logic             space;
  logic             xfer_c;
  logic             oor_drop;
  logic             sel_err_q, sel_err_d;

  // Target decode, join readiness and one-hot push vector.
  always_comb begin
    hit       = '0;
    tgt_space = 1'b0;
    push      = '0;
    oor_drop  = 1'b0;
    for (int i = 0; i < NOUT; i++) begin
      if (bus.s_sel == SELW'(i)) begin
        hit[i]    = 1'b1;
        tgt_space = ~full[i];
      end
    end
    in_range = |hit;
    if (bus.s_bcast)   space = ~|full;
    else if (in_range) space = tgt_space;
    else               space = 1'b1;
    xfer_c = rst_n & bus.l_valid & bus.s_valid & space;
    if (xfer_c) begin
      if (bus.s_bcast)   push = '1;
      else if (in_range) push = hit;
      else               oor_drop = 1'b1;
    end
    sel_err_d = sel_err_q | oor_drop;
  end

  // Sticky out-of-range drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  for (genvar g = 0; g < NOUT; g++) begin : g_out
    split_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[g]),
      .data_i  (bus.l_data),
      .pop_i   (pop[g]),
      .count_o (cnt[g]),
      .head_o  (head[g])
    );
    assign full[g]                      = (cnt[g] == CNT_W'(DEPTH));
    assign bus.r_valid[g]               = (cnt[g] != '0);
    assign pop[g]                       = bus.r_valid[g] & bus.r_ready[g];
    assign bus.r_data[g*WIDTH +: WIDTH] = head[g];
  end

  assign bus.l_ready = xfer_c;
  assign bus.s_ready = xfer_c;
  assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_split_n.sv
// Directed bench for split_n: table-driven stream plus hand-written corner sequences.
module tb_split_n;

  logic clk;
  logic rst_n;
  logic err4, err3;
  int   checks;
  int   errors;

  split_n_if #(.WIDTH(8), .NOUT(4)) bus4 ();
  split_n_if #(.WIDTH(8), .NOUT(3)) bus3 ();

  split_n #(.WIDTH(8), .NOUT(4), .DEPTH(2)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus4),
    .sel_err (err4)
  );

  split_n #(.WIDTH(8), .NOUT(3), .DEPTH(2)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus3),
    .sel_err (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [7:0]  ld;
    logic        sv;
    logic [1:0]  sel;
    logic        bc;
    logic [3:0]  rr;
    logic        exp_rdy;
    logic [3:0]  exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(logic lv, logic [7:0] ld, logic sv, logic [1:0] sel, logic bc,
                              logic [3:0] rr, logic rdy, logic [3:0] rv, logic [31:0] rd);
    vec_t v;
    v.lv = lv; v.ld = ld; v.sv = sv; v.sel = sel; v.bc = bc; v.rr = rr;
    v.exp_rdy = rdy; v.exp_rv = rv; v.exp_rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive4(input logic lv, input logic [7:0] ld, input logic sv,
                        input logic [1:0] sel, input logic bc, input logic [3:0] rr);
    bus4.l_valid = lv;
    bus4.l_data  = ld;
    bus4.s_valid = sv;
    bus4.s_sel   = sel;
    bus4.s_bcast = bc;
    bus4.r_ready = rr;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] rv);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (rv[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = mk(1, 8'h11, 1, 2'd2, 0, 4'hF, 1, 4'b0100, 32'h0011_0000);
    vecs[1]  = mk(1, 8'h22, 1, 2'd0, 0, 4'hF, 1, 4'b0001, 32'h0000_0022);
    vecs[2]  = mk(0, 8'h00, 0, 2'd0, 0, 4'hF, 0, 4'b0000, 32'h0);
    vecs[3]  = mk(1, 8'h31, 1, 2'd1, 0, 4'hD, 1, 4'b0010, 32'h0000_3100);
    vecs[4]  = mk(1, 8'h32, 1, 2'd1, 0, 4'hD, 1, 4'b0010, 32'h0000_3100);
    vecs[5]  = mk(1, 8'h33, 1, 2'd1, 0, 4'hD, 0, 4'b0010, 32'h0000_3100);
    vecs[6]  = mk(1, 8'h33, 1, 2'd1, 0, 4'hF, 0, 4'b0010, 32'h0000_3200);
    vecs[7]  = mk(1, 8'h33, 1, 2'd1, 0, 4'hF, 1, 4'b0010, 32'h0000_3300);
    vecs[8]  = mk(0, 8'h00, 0, 2'd0, 0, 4'hF, 0, 4'b0000, 32'h0);
    for (int i = 9; i < 14; i++)
      vecs[i] = mk(1, 8'h44, 0, 2'd3, 0, 4'hF, 0, 4'b0000, 32'h0);
    vecs[14] = mk(1, 8'h44, 1, 2'd3, 0, 4'hF, 1, 4'b1000, 32'h4400_0000);
    vecs[15] = mk(0, 8'h00, 0, 2'd0, 0, 4'hF, 0, 4'b0000, 32'h0);

    // Reset with both valids high: ready must stay low.
    rst_n = 1'b0;
    drive4(1, 8'h5A, 1, 2'd0, 0, 4'hF);
    bus3.l_valid = 1'b1; bus3.l_data = 8'h00; bus3.s_valid = 1'b1;
    bus3.s_sel = 2'd0; bus3.s_bcast = 1'b0; bus3.r_ready = 3'b111;
    #3;
    chk("rst_rvalid", 32'(bus4.r_valid), 32'h0);
    chk("rst_rdata", bus4.r_data, 32'h0);
    chk("rst_lready", 32'(bus4.l_ready), 32'h0);
    chk("rst_sready", 32'(bus4.s_ready), 32'h0);
    chk("rst_selerr", 32'(err3), 32'h0);
    #9;
    drive4(0, 8'h00, 0, 2'd0, 0, 4'hF);
    bus3.l_valid = 1'b0; bus3.s_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Unicast, backpressure and join stream.
    for (int i = 0; i < 16; i++) begin
      drive4(vecs[i].lv, vecs[i].ld, vecs[i].sv, vecs[i].sel, vecs[i].bc, vecs[i].rr);
      #1;
      chk($sformatf("v%0d_lready", i), 32'(bus4.l_ready), 32'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_sready", i), 32'(bus4.s_ready), 32'(vecs[i].exp_rdy));
      tick();
      m = lane_mask(vecs[i].exp_rv);
      chk($sformatf("v%0d_rvalid", i), 32'(bus4.r_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("v%0d_rdata", i), bus4.r_data & m, vecs[i].exp_rd & m);
    end

    // Broadcast held while output 3 is full, released once it drains one.
    drive4(1, 8'h51, 1, 2'd3, 0, 4'b0111);
    #1 chk("bc_fill1_rdy", 32'(bus4.l_ready), 32'h1);
    tick();
    drive4(1, 8'h52, 1, 2'd3, 0, 4'b0111);
    #1 chk("bc_fill2_rdy", 32'(bus4.l_ready), 32'h1);
    tick();
    drive4(1, 8'hA5, 1, 2'd0, 1, 4'b0111);
    for (int i = 0; i < 2; i++) begin
      #1 chk("bc_held_rdy", 32'(bus4.l_ready), 32'h0);
      tick();
      chk("bc_held_rvalid", 32'(bus4.r_valid), 32'h8);
      chk("bc_held_rdata", bus4.r_data & 32'hFF00_0000, 32'h5100_0000);
    end
    bus4.r_ready = 4'hF;
    #1 chk("bc_drain_rdy", 32'(bus4.l_ready), 32'h0);
    tick();
    chk("bc_drain_rdata", bus4.r_data & 32'hFF00_0000, 32'h5200_0000);
    #1 chk("bc_go_rdy", 32'(bus4.s_ready), 32'h1);
    tick();
    chk("bc_all_rvalid", 32'(bus4.r_valid), 32'hF);
    chk("bc_all_rdata", bus4.r_data, 32'hA5A5_A5A5);
    drive4(0, 8'h00, 0, 2'd0, 0, 4'hF);
    tick();
    chk("bc_empty_rvalid", 32'(bus4.r_valid), 32'h0);

    // Out-of-range select on the three-output instance.
    bus3.l_valid = 1'b1; bus3.l_data = 8'h7E; bus3.s_valid = 1'b1; bus3.s_sel = 2'd3;
    #1 chk("oor_lready", 32'(bus3.l_ready), 32'h1);
    chk("oor_selerr_pre", 32'(err3), 32'h0);
    tick();
    bus3.l_valid = 1'b0; bus3.s_valid = 1'b0; bus3.s_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      chk("oor_rvalid", 32'(bus3.r_valid), 32'h0);
      chk("oor_selerr", 32'(err3), 32'h1);
      tick();
    end

    // Reset mid-operation with two tokens buffered in output 0.
    drive4(1, 8'h61, 1, 2'd0, 0, 4'hE);
    tick();
    drive4(1, 8'h62, 1, 2'd0, 0, 4'hE);
    tick();
    drive4(1, 8'h63, 1, 2'd0, 0, 4'hE);
    chk("mid_rvalid_pre", 32'(bus4.r_valid), 32'h1);
    chk("mid_rdata_pre", bus4.r_data & 32'hFF, 32'h61);
    #1 chk("mid_full_rdy", 32'(bus4.l_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus4.r_valid), 32'h0);
    chk("mid_rst_rdata", bus4.r_data, 32'h0);
    chk("mid_rst_lready", 32'(bus4.l_ready), 32'h0);
    chk("mid_rst_selerr", 32'(err3), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus4.r_ready = 4'hF;
    #1 chk("post_rst_rdy", 32'(bus4.l_ready), 32'h1);
    tick();
    drive4(0, 8'h00, 0, 2'd0, 0, 4'hF);
    chk("post_rst_rvalid", 32'(bus4.r_valid), 32'h1);
    chk("post_rst_rdata", bus4.r_data & 32'hFF, 32'h63);
    tick();
    chk("post_rst_empty", 32'(bus4.r_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
